// File: rtl/id_ex_alu_decode_pkg.sv
// Shared ALU decode definitions: ALUCode values, MIPS opcode/funct encodings
// and the operand-select controls passed from the decoder to the EX register.
package id_ex_alu_decode_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_AND  = 5'd1;
  localparam logic [4:0] ALU_XOR  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_NOR  = 5'd4;
  localparam logic [4:0] ALU_SUB  = 5'd5;
  localparam logic [4:0] ALU_ANDI = 5'd6;
  localparam logic [4:0] ALU_XORI = 5'd7;
  localparam logic [4:0] ALU_ORI  = 5'd8;
  localparam logic [4:0] ALU_SLL  = 5'd16;
  localparam logic [4:0] ALU_SRL  = 5'd17;
  localparam logic [4:0] ALU_SRA  = 5'd18;
  localparam logic [4:0] ALU_SLT  = 5'd19;
  localparam logic [4:0] ALU_SLTU = 5'd20;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // lui is executed as "imm16 << 16" on the shifter, so A carries the amount
  localparam int LUI_SHIFT = 16;

  typedef enum logic [1:0] {A_SEL_ZERO, A_SEL_RS, A_SEL_SHAMT, A_SEL_LUI} a_sel_e;
  typedef enum logic [1:0] {B_SEL_ZERO, B_SEL_RT, B_SEL_SEXT, B_SEL_ZEXT} b_sel_e;
  typedef enum logic [1:0] {DST_SEL_ZERO, DST_SEL_RD, DST_SEL_RT} dst_sel_e;

endpackage

// File: rtl/id_ex_alu_decode_if.sv
// ID-to-EX bundle: decode inputs, pipeline control and registered EX outputs.
// ex_illegal exists only when DECODE_ILLEGAL_EN is defined.
interface id_ex_alu_decode_if #(parameter int DATA_W = 32);
  logic              id_valid;
  logic [31:0]       id_instr;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic              stall;
  logic              flush;
  logic              ex_valid;
  logic [4:0]        ex_alu_code;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [4:0]        ex_dst;
  logic              ex_reg_write;
`ifdef DECODE_ILLEGAL_EN
  logic              ex_illegal;
`endif

  modport master (
    output id_valid, id_instr, id_rs_data, id_rt_data, stall, flush,
`ifdef DECODE_ILLEGAL_EN
    input  ex_illegal,
`endif
    input  ex_valid, ex_alu_code, ex_a, ex_b, ex_dst, ex_reg_write
  );

  modport slave (
    input  id_valid, id_instr, id_rs_data, id_rt_data, stall, flush,
`ifdef DECODE_ILLEGAL_EN
    output ex_illegal,
`endif
    output ex_valid, ex_alu_code, ex_a, ex_b, ex_dst, ex_reg_write
  );
endinterface

// File: rtl/id_ex_alu_decode_alu_ctrl_dec.sv
// Combinational ALU control decoder: opcode/funct to ALUCode, operand
// selects and writeback enable; unknown encodings come out as a flagged NOP.
module alu_ctrl_dec
  import id_ex_alu_decode_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [4:0] alu_code,
  output a_sel_e     a_sel,
  output b_sel_e     b_sel,
  output dst_sel_e   dst_sel,
  output logic       reg_write,
  output logic       illegal
);

  always_comb begin
    alu_code  = ALU_ADD;
    a_sel     = A_SEL_ZERO;
    b_sel     = B_SEL_ZERO;
    dst_sel   = DST_SEL_ZERO;
    reg_write = 1'b0;
    illegal   = 1'b1;

    if (opcode == OP_RTYPE) begin
      illegal   = 1'b0;
      a_sel     = A_SEL_RS;
      b_sel     = B_SEL_RT;
      dst_sel   = DST_SEL_RD;
      reg_write = 1'b1;
      case (funct)
        FN_ADD, FN_ADDU: alu_code = ALU_ADD;
        FN_SUB, FN_SUBU: alu_code = ALU_SUB;
        FN_AND:          alu_code = ALU_AND;
        FN_OR:           alu_code = ALU_OR;
        FN_XOR:          alu_code = ALU_XOR;
        FN_NOR:          alu_code = ALU_NOR;
        FN_SLT:          alu_code = ALU_SLT;
        FN_SLTU:         alu_code = ALU_SLTU;
        FN_SLL: begin alu_code = ALU_SLL; a_sel = A_SEL_SHAMT; end
        FN_SRL: begin alu_code = ALU_SRL; a_sel = A_SEL_SHAMT; end
        FN_SRA: begin alu_code = ALU_SRA; a_sel = A_SEL_SHAMT; end
        default: begin
          illegal   = 1'b1;
          a_sel     = A_SEL_ZERO;
          b_sel     = B_SEL_ZERO;
          dst_sel   = DST_SEL_ZERO;
          reg_write = 1'b0;
        end
      endcase
    end else begin
      illegal   = 1'b0;
      a_sel     = A_SEL_RS;
      b_sel     = B_SEL_SEXT;
      dst_sel   = DST_SEL_RT;
      reg_write = 1'b1;
      // andi/ori/xori still get the sign-extended immediate; the ALU masks it
      case (opcode)
        OP_ADDI, OP_ADDIU: alu_code = ALU_ADD;
        OP_ANDI:           alu_code = ALU_ANDI;
        OP_XORI:           alu_code = ALU_XORI;
        OP_ORI:            alu_code = ALU_ORI;
        OP_SLTI:           alu_code = ALU_SLT;
        OP_SLTIU:          alu_code = ALU_SLTU;
        OP_LUI: begin
          alu_code = ALU_SLL;
          a_sel    = A_SEL_LUI;
          b_sel    = B_SEL_ZEXT;
        end
        default: begin
          illegal   = 1'b1;
          a_sel     = A_SEL_ZERO;
          b_sel     = B_SEL_ZERO;
          dst_sel   = DST_SEL_ZERO;
          reg_write = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/id_ex_alu_decode.sv
// ID/EX stage register with ALU decode: operand muxing plus the EX flops.
// Define DECODE_ILLEGAL_EN to add the registered ex_illegal output.
module id_ex_alu_decode
  import id_ex_alu_decode_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  id_ex_alu_decode_if.slave    bus
);

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [4:0]        rt_f;
  logic [4:0]        rd_f;
  logic [4:0]        shamt;
  logic [15:0]       imm16;

  logic [4:0]        dec_alu_code;
  a_sel_e            dec_a_sel;
  b_sel_e            dec_b_sel;
  dst_sel_e          dec_dst_sel;
  logic              dec_reg_write;
  logic              dec_illegal;

  logic [DATA_W-1:0] a_mux;
  logic [DATA_W-1:0] b_mux;
  logic [4:0]        dst_mux;

  logic              valid_q,     valid_d;
  logic [4:0]        alu_code_q,  alu_code_d;
  logic [DATA_W-1:0] a_q,         a_d;
  logic [DATA_W-1:0] b_q,         b_d;
  logic [4:0]        dst_q,       dst_d;
  logic              reg_write_q, reg_write_d;
`ifdef DECODE_ILLEGAL_EN
  logic              illegal_q,   illegal_d;
`endif

  assign opcode = bus.id_instr[31:26];
  assign rt_f   = bus.id_instr[20:16];
  assign rd_f   = bus.id_instr[15:11];
  assign shamt  = bus.id_instr[10:6];
  assign funct  = bus.id_instr[5:0];
  assign imm16  = bus.id_instr[15:0];

  alu_ctrl_dec u_dec (
    .opcode    (opcode),
    .funct     (funct),
    .alu_code  (dec_alu_code),
    .a_sel     (dec_a_sel),
    .b_sel     (dec_b_sel),
    .dst_sel   (dec_dst_sel),
    .reg_write (dec_reg_write),
    .illegal   (dec_illegal)
  );

  always_comb begin
    a_mux = '0;
    case (dec_a_sel)
      A_SEL_RS:    a_mux = bus.id_rs_data;
      A_SEL_SHAMT: a_mux = DATA_W'(shamt);
      A_SEL_LUI:   a_mux = DATA_W'(LUI_SHIFT);
      default:     a_mux = '0;
    endcase

    b_mux = '0;
    case (dec_b_sel)
      B_SEL_RT:   b_mux = bus.id_rt_data;
      B_SEL_SEXT: b_mux = DATA_W'($signed(imm16));
      B_SEL_ZEXT: b_mux = DATA_W'(imm16);
      default:    b_mux = '0;
    endcase

    dst_mux = '0;
    case (dec_dst_sel)
      DST_SEL_RD: dst_mux = rd_f;
      DST_SEL_RT: dst_mux = rt_f;
      default:    dst_mux = '0;
    endcase
  end

  // Priority: flush beats stall, stall beats a fresh load or an id bubble
  always_comb begin
    valid_d     = valid_q;
    alu_code_d  = alu_code_q;
    a_d         = a_q;
    b_d         = b_q;
    dst_d       = dst_q;
    reg_write_d = reg_write_q;
`ifdef DECODE_ILLEGAL_EN
    illegal_d   = illegal_q;
`endif
    if (bus.flush || (!bus.stall && !bus.id_valid)) begin
      valid_d     = 1'b0;
      alu_code_d  = '0;
      a_d         = '0;
      b_d         = '0;
      dst_d       = '0;
      reg_write_d = 1'b0;
`ifdef DECODE_ILLEGAL_EN
      illegal_d   = 1'b0;
`endif
    end else if (!bus.stall) begin
      valid_d     = 1'b1;
      alu_code_d  = dec_illegal ? ALU_ADD : dec_alu_code;
      a_d         = a_mux;
      b_d         = b_mux;
      dst_d       = dst_mux;
      reg_write_d = dec_reg_write & ~dec_illegal;
`ifdef DECODE_ILLEGAL_EN
      illegal_d   = dec_illegal;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      alu_code_q  <= '0;
      a_q         <= '0;
      b_q         <= '0;
      dst_q       <= '0;
      reg_write_q <= 1'b0;
`ifdef DECODE_ILLEGAL_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      valid_q     <= valid_d;
      alu_code_q  <= alu_code_d;
      a_q         <= a_d;
      b_q         <= b_d;
      dst_q       <= dst_d;
      reg_write_q <= reg_write_d;
`ifdef DECODE_ILLEGAL_EN
      illegal_q   <= illegal_d;
`endif
    end
  end

  assign bus.ex_valid     = valid_q;
  assign bus.ex_alu_code  = alu_code_q;
  assign bus.ex_a         = a_q;
  assign bus.ex_b         = b_q;
  assign bus.ex_dst       = dst_q;
  assign bus.ex_reg_write = reg_write_q;
`ifdef DECODE_ILLEGAL_EN
  assign bus.ex_illegal   = illegal_q;
`endif

endmodule

// File: doc/id_ex_alu_decode.md
ID_EX_ALU_DECODE -- requirements
Module: id_ex_alu_decode

Interface
REQ-001 Parameter DATA_W, 32, operand and result datapath width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 id_valid  input  1  ID stage holds a valid instruction.
REQ-005 id_instr  input  32  MIPS instruction word from IF/ID.
REQ-006 id_rs_data, id_rt_data  input  DATA_W each  register-file read data for rs and rt.
REQ-007 stall  input  1  hold all EX-side registers.
REQ-008 flush  input  1  replace the next EX contents with a bubble.
REQ-009 ex_valid  output  1  the EX slot holds a real instruction.
REQ-010 ex_alu_code  output  5  ALUCode presented to the ALU.
REQ-011 ex_a, ex_b  output  DATA_W each  ALU operands A and B.
REQ-012 ex_dst  output  5  destination register number.
REQ-013 ex_reg_write  output  1  writeback enable.

Function
REQ-014 The block SHALL decode id_instr combinationally and register the result into the EX outputs with exactly one cycle of latency.
REQ-015 ALUCode encoding SHALL be: add=0, and=1, xor=2, or=3, nor=4, sub=5, andi=6, xori=7, ori=8, sll=16, srl=17, sra=18, slt=19, sltu=20.
REQ-016 R-type instructions (opcode 0) SHALL decode by funct as follows: 0x20/0x21->0, 0x22/0x23->5, 0x24->1, 0x25->3, 0x26->2, 0x27->4, 0x2A->19, 0x2B->20, 0x00->16, 0x02->17, 0x03->18.
- A=rs data, B=rt data.
- dst=rd, reg_write=1.
REQ-017 R-type shifts SHALL set A={27'b0, shamt} and B=rt data.
REQ-018 I-type instructions SHALL decode by opcode as follows: 0x08/0x09->0, 0x0C->6, 0x0E->7, 0x0D->8, 0x0A->19, 0x0B->20.
- A=rs data, B=sign-extended imm16.
- dst=rt, reg_write=1.
- The ALU zero-extends B[15:0] itself for codes 6-8.
REQ-019 lui (0x0F) SHALL decode to code 16 with A=16, B={16'b0, imm16}, dst=rt, reg_write=1.
REQ-020 Any other encoding SHALL decode to a NOP: code 0, A=B=0, dst=0, reg_write=0, ex_valid=id_valid.
REQ-021 id_valid=0 SHALL load a bubble: ex_valid=0, reg_write=0, code 0, A=B=0, dst=0.
REQ-022 stall=1 SHALL hold every EX output unchanged.
REQ-023 flush=1 SHALL load a bubble on the next edge.
REQ-024 If stall and flush are both 1, flush SHALL win.
REQ-025 Outputs SHALL be driven only from registers (no combinational input-to-output path).

Reset
REQ-026 rst_n low SHALL immediately force all outputs to 0 (bubble state).
- Also applies mid-operation, regardless of stall or flush.
REQ-027 The first capture after reset deasserts SHALL occur on the first rising clk edge with rst_n high.

Configuration
REQ-028 With macro DECODE_ILLEGAL_EN defined, the block SHALL add output ex_illegal (1 bit).
- ex_illegal SHALL be registered alongside the other EX outputs.
- It SHALL be 1 when a valid instruction hits REQ-020, and 0 otherwise.
- It SHALL be cleared by bubble, flush and reset.
REQ-029 Without DECODE_ILLEGAL_EN, the ex_illegal port SHALL NOT exist and illegal encodings SHALL decode silently as NOPs.

Structure
REQ-030 A shared package SHALL hold the ALUCode constants, opcode constants and funct constants, so that the ALU and this block use one definition.
REQ-031 The combinational decoder SHALL be a sub-module named alu_ctrl_dec.
- Inputs: opcode, funct.
- Outputs: alu_code, operand-select controls, reg_write, illegal.
- The top module contains only operand muxing and the EX register.

Verification
REQ-032 Scenario 1: add $3,$1,$2 with rs=0x40000000, rt=0x40000000 -> next cycle code=0, A=0x40000000, B=0x40000000, dst=3, reg_write=1, ex_valid=1.
REQ-033 Scenario 2: sll $4,$5,4 with rt=0xFFFFE0FF -> code=16, A=0x00000004, B=0xFFFFE0FF, dst=4.
REQ-034 Scenario 3: andi $6,$7,0xE0FF with rs=0xFF0C0E10 -> code=6, A=0xFF0C0E10, B=0xFFFFE0FF, dst=6.
REQ-035 Scenario 4: lui $8,0x1234 -> code=16, A=0x10, B=0x00001234, dst=8.
REQ-036 Scenario 5: stall=1 for 3 cycles while id_instr changes -> outputs hold the scenario-4 values; stall=1 with flush=1 -> bubble (all zero).
REQ-037 Scenario 6: instruction 0xFC000000 with DECODE_ILLEGAL_EN defined -> ex_illegal=1, reg_write=0, ex_valid=1; then rst_n pulsed low mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
